// File: rtl/rv32_execute.sv
// RV32 execute stage: ALU, single-cycle RV32M multiply and an iterative radix-2 divider
// that stalls upstream. Results and memory-stage control are registered on the output.
//
// state | meaning
// IDLE  | accept ALU/MUL ops each cycle; a divide op latches operands and starts the engine
// RUN   | one quotient bit per cycle for 32 cycles, upstream held via stall_out
// DONE  | sign fixup applied, result registered with the held control fields
module rv32_execute #(
  parameter bit DIV_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic [4:0]  op_in,
  input  logic [31:0] src1_in,
  input  logic [31:0] src2_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  input  logic        read_en_in,
  input  logic        write_en_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_writeback_in,
  output logic        stall_out,
  output logic [31:0] result_out,
  output logic [31:0] rs2_value_out,
  output logic [31:0] branch_pc_out,
  output logic        read_en_out,
  output logic        write_en_out,
  output logic        rd_writeback_out,
  output logic [1:0]  branch_op_out,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [31:0] result_q, rs2_value_q, branch_pc_q;
  logic        read_en_q, write_en_q, rd_writeback_q;
  logic [1:0]  branch_op_q;
  logic [4:0]  rd_q;

  logic [31:0] quo_q, rem_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q, neg_rem_q;

  logic        is_div;
  logic [63:0] mul_a, mul_b, mul_p;
  logic [31:0] alu_res, div_res, quo_fix, rem_fix, res_d;
  logic [32:0] rem_shift, diff;
  logic        ge;
  logic [31:0] quo_d, rem_d;
  logic        accept_d;

  assign is_div = DIV_ENABLE && (op_in[4:2] == 3'b101);

  // One 64-bit multiplier; operand extension selects signed/unsigned variants.
  always_comb begin
    mul_a = {{32{(op_in[1:0] != 2'b11) & src1_in[31]}}, src1_in};
    mul_b = {{32{(op_in[1:0] == 2'b01) & src2_in[31]}}, src2_in};
    mul_p = mul_a * mul_b;
  end

  always_comb begin
    alu_res = 32'd0;
    case (op_in)
      5'd0:  alu_res = src1_in + src2_in;
      5'd1:  alu_res = src1_in - src2_in;
      5'd2:  alu_res = src1_in << src2_in[4:0];
      5'd3:  alu_res = {31'd0, $signed(src1_in) < $signed(src2_in)};
      5'd4:  alu_res = {31'd0, src1_in < src2_in};
      5'd5:  alu_res = src1_in ^ src2_in;
      5'd6:  alu_res = src1_in >> src2_in[4:0];
      5'd7:  alu_res = $unsigned($signed(src1_in) >>> src2_in[4:0]);
      5'd8:  alu_res = src1_in | src2_in;
      5'd9:  alu_res = src1_in & src2_in;
      5'd16: alu_res = mul_p[31:0];
      5'd17, 5'd18, 5'd19: alu_res = mul_p[63:32];
      default: alu_res = 32'd0;
    endcase
  end

  // Restoring division step: remainder fits 32 bits since it stays below the divisor,
  // and with a zero divisor it only ever holds already-shifted dividend bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    ge        = ~diff[32];
    rem_d     = ge ? diff[31:0] : rem_shift[31:0];
    quo_d     = {quo_q[30:0], ge};
  end

  // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
  always_comb begin
    quo_fix = (neg_quo_q && (dvs_q != 32'd0)) ? (32'd0 - quo_q) : quo_q;
    rem_fix = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    div_res = op_in[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    stall_out = reset_n && !flush_in &&
                (((state_q == IDLE) && valid_in && is_div) || (state_q == RUN));
    accept_d  = !flush_in && valid_in &&
                (((state_q == IDLE) && !is_div) || (state_q == DONE));
    res_d     = (state_q == DONE) ? div_res : alu_res;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      result_q       <= '0;
      rs2_value_q    <= '0;
      branch_pc_q    <= '0;
      read_en_q      <= 1'b0;
      write_en_q     <= 1'b0;
      rd_writeback_q <= 1'b0;
      branch_op_q    <= '0;
      rd_q           <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      dvs_q          <= '0;
      cnt_q          <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
    end else begin
      if (accept_d) begin
        result_q       <= res_d;
        rs2_value_q    <= rs2_value_in;
        branch_pc_q    <= branch_pc_in;
        read_en_q      <= read_en_in;
        write_en_q     <= write_en_in;
        rd_writeback_q <= rd_writeback_in;
        branch_op_q    <= branch_op_in;
        rd_q           <= rd_in;
      end else begin
        result_q       <= '0;
        rs2_value_q    <= '0;
        branch_pc_q    <= '0;
        read_en_q      <= 1'b0;
        write_en_q     <= 1'b0;
        rd_writeback_q <= 1'b0;
        branch_op_q    <= '0;
        rd_q           <= '0;
      end

      if (flush_in) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_in && is_div) begin
              quo_q     <= (!op_in[0] && src1_in[31]) ? (32'd0 - src1_in) : src1_in;
              dvs_q     <= (!op_in[0] && src2_in[31]) ? (32'd0 - src2_in) : src2_in;
              neg_quo_q <= !op_in[0] && (src1_in[31] ^ src2_in[31]);
              neg_rem_q <= !op_in[0] && src1_in[31];
              rem_q     <= '0;
              cnt_q     <= '0;
              state_q   <= RUN;
            end
          end
          RUN: begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign result_out       = result_q;
  assign rs2_value_out    = rs2_value_q;
  assign branch_pc_out    = branch_pc_q;
  assign read_en_out      = read_en_q;
  assign write_en_out     = write_en_q;
  assign rd_writeback_out = rd_writeback_q;
  assign branch_op_out    = branch_op_q;
  assign rd_out           = rd_q;

endmodule

// File: tb/tb_rv32_execute.sv
// Directed and randomized checks of rv32_execute against an arithmetic reference model.
module tb_rv32_execute;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in, flush_in;
  logic [4:0]  op_in;
  logic [31:0] src1_in, src2_in, rs2_value_in, branch_pc_in;
  logic        read_en_in, write_en_in, rd_writeback_in;
  logic [1:0]  branch_op_in;
  logic [4:0]  rd_in;
  logic        stall_out;
  logic [31:0] result_out, rs2_value_out, branch_pc_out;
  logic        read_en_out, write_en_out, rd_writeback_out;
  logic [1:0]  branch_op_out;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] e_rs2, e_bpc;
  logic        e_re, e_we, e_wb;
  logic [1:0]  e_bop;
  logic [4:0]  e_rd;

  rv32_execute #(.DIV_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush_in(flush_in),
    .op_in(op_in), .src1_in(src1_in), .src2_in(src2_in),
    .rs2_value_in(rs2_value_in), .branch_pc_in(branch_pc_in),
    .read_en_in(read_en_in), .write_en_in(write_en_in),
    .branch_op_in(branch_op_in), .rd_in(rd_in), .rd_writeback_in(rd_writeback_in),
    .stall_out(stall_out), .result_out(result_out), .rs2_value_out(rs2_value_out),
    .branch_pc_out(branch_pc_out), .read_en_out(read_en_out),
    .write_en_out(write_en_out), .rd_writeback_out(rd_writeback_out),
    .branch_op_out(branch_op_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    longint unsigned pu;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return (sa < sb) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return sa >>> b[4:0];
      8: return a | b;
      9: return a & b;
      16: begin pu = longint'(a) * longint'(b); return pu[31:0]; end
      17: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      18: begin p = longint'(sa) * longint'(b); return p[63:32]; end
      19: begin pu = longint'(a) * longint'(b); return pu[63:32]; end
      20: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      21: return (b == 0) ? 32'hFFFFFFFF : a / b;
      22: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_word();
    return {22'd0, read_en_out, write_en_out, branch_op_out, rd_out, rd_writeback_out};
  endfunction

  task automatic check_all(input string tag, input logic [31:0] exp);
    chk({tag, "_result"}, result_out, exp);
    chk({tag, "_rs2"}, rs2_value_out, e_rs2);
    chk({tag, "_bpc"}, branch_pc_out, e_bpc);
    chk({tag, "_ctl"}, ctl_word(), {22'd0, e_re, e_we, e_bop, e_rd, e_wb});
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, "_result"}, result_out, 32'd0);
    chk({tag, "_data"}, rs2_value_out | branch_pc_out, 32'd0);
    chk({tag, "_ctl"}, ctl_word(), 32'd0);
  endtask

  task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rs2, input logic [31:0] bpc, input logic re,
                         input logic we, input logic [1:0] bop, input logic [4:0] rd,
                         input logic wb);
    valid_in = 1'b1; op_in = op; src1_in = a; src2_in = b;
    rs2_value_in = rs2; branch_pc_in = bpc; read_en_in = re; write_en_in = we;
    branch_op_in = bop; rd_in = rd; rd_writeback_in = wb;
    e_rs2 = rs2; e_bpc = bpc; e_re = re; e_we = we; e_bop = bop; e_rd = rd; e_wb = wb;
  endtask

  // Called just after a rising edge; returns just after the edge that delivers the result.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] rs2, input logic [31:0] bpc,
                        input logic re, input logic we, input logic [1:0] bop,
                        input logic [4:0] rd, input logic wb);
    logic [31:0] exp;
    bit div;
    int cyc;
    present(op, a, b, rs2, bpc, re, we, bop, rd, wb);
    exp = ref_model(int'(op), a, b);
    div = (op >= 20 && op <= 23);
    #1;
    chk({tag, "_stall0"}, {31'd0, stall_out}, {31'd0, div});
    if (div) begin
      cyc = 0;
      while (stall_out && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        check_bubble({tag, "_stallbub"});
      end
      chk({tag, "_stallcycles"}, cyc, 33);
    end
    @(posedge clk); #1;
    check_all(tag, exp);
    valid_in = 1'b0;
  endtask

  task automatic rand_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    run_op("rand", op, a, b, $urandom, $urandom, 1'($urandom), 1'($urandom),
           2'($urandom), 5'($urandom), 1'($urandom));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ops[20];
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21, 22, 23, 12, 31};
    reset_n = 1'b0;
    present(5'd20, 32'd100, 32'd7, 32'd1, 32'd2, 1'b1, 1'b1, 2'd1, 5'd1, 1'b1);
    flush_in = 1'b0;
    #3;
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    check_bubble("reset_out");
    valid_in = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_bubble("idle_bubble");

    run_op("add", 5'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd3, 1'b1);
    run_op("sra", 5'd7, 32'h80000000, 32'h24, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd4, 1'b1);
    chk("sra_value", result_out, 32'hF8000000);
    run_op("sltu", 5'd4, 32'd1, 32'hFFFFFFFF, 32'h11, 32'h22, 1'b1, 1'b0, 2'd2, 5'd5, 1'b1);
    run_op("mulh", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd6, 1'b1);
    run_op("mulhu", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd7, 1'b1);
    chk("mulhu_value", result_out, 32'hFFFFFFFE);
    run_op("mul", 5'd16, 32'h10000, 32'h10000, 32'd0, 32'd0, 1'b0, 1'b1, 2'd3, 5'd8, 1'b0);
    run_op("div", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hAA, 32'hBB, 1'b0, 1'b0, 2'd0, 5'd9, 1'b1);
    chk("div_value", result_out, 32'hFFFFFFFD);
    run_op("rem", 5'd22, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd10, 1'b1);
    run_op("divu0", 5'd21, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd11, 1'b1);
    run_op("remu0", 5'd23, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd12, 1'b1);
    chk("remu0_value", result_out, 32'd9);
    run_op("divovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd13, 1'b1);
    run_op("removf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd14, 1'b1);
    run_op("divneg0", 5'd20, 32'hFFFFFFF0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd15, 1'b1);
    run_op("unknown", 5'd10, 32'd3, 32'd4, 32'd5, 32'd6, 1'b1, 1'b0, 2'd1, 5'd16, 1'b1);

    // Flush at the tenth RUN cycle, then an ADD right behind it.
    present(5'd21, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd17, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("flush_pre_stall", {31'd0, stall_out}, 32'd1);
    flush_in = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    check_bubble("flush_bubble");
    flush_in = 1'b0;
    run_op("post_flush_add", 5'd0, 32'd20, 32'd22, 32'd1, 32'd2, 1'b0, 1'b1, 2'd0, 5'd18, 1'b1);

    // Asynchronous reset clears live outputs without a clock edge.
    run_op("pre_reset_add", 5'd0, 32'd1, 32'd2, 32'h5, 32'h6, 1'b1, 1'b1, 2'd3, 5'd19, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_bubble("async_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset mid-divide: the next divide must take the full latency again.
    present(5'd20, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd20, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("middiv_reset_stall", {31'd0, stall_out}, 32'd0);
    check_bubble("middiv_reset_out");
    valid_in = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset_add", 5'd0, 32'd8, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd21, 1'b1);
    run_op("post_reset_div", 5'd20, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 5'd22, 1'b1);

    for (int i = 0; i < 60; i++) begin
      rand_op(5'(ops[$urandom_range(0, 19)]), rnd_val(), rnd_val());
    end

    @(posedge clk); #1;
    check_bubble("final_bubble");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
